// File: rtl/apb_initiator_pkg.sv
// Shared definitions for the APB initiator: FSM encoding and timeout defaults.
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int          CNT_W              = 10;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase cycle counter; expired flags the last permitted ACCESS cycle.
module apb_timeout_cnt
    import apb_initiator_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at the terminal count so a stuck enable can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT_M1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: host request in, one-cycle response pulse out,
// with an ACCESS-phase timeout that reports rsp_err.
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] apb_addr,
    output logic        apb_sel,
    output logic        apb_write,
    output logic        apb_ena,
    output logic [31:0] apb_wdata,
    output logic [3:0]  apb_pstb,
    input  logic [31:0] apb_rdata,
    input  logic        apb_rready
);

    apb_state_e  state_q;
    logic        ready_q, sel_q, ena_q, write_q, rsp_valid_q, rsp_err_q;
    logic [31:0] addr_q, wdata_q, rsp_rdata_q;
    logic [3:0]  pstb_q;
    logic        cnt_clear, cnt_en, expired;

    assign cnt_clear = (state_q == SETUP);
    assign cnt_en    = (state_q == ACCESS);

    apb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clock  (clock),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            sel_q       <= 1'b0;
            ena_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pstb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        sel_q   <= 1'b1;
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pstb_q  <= req_write ? req_strb : 4'b0000;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    ena_q   <= 1'b1;
                end
                ACCESS: begin
                    // A ready on the final counted cycle still completes normally.
                    if (apb_rready || expired) begin
                        state_q     <= RESP;
                        sel_q       <= 1'b0;
                        ena_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ~apb_rready;
                        rsp_rdata_q <= (apb_rready && !write_q) ? apb_rdata : 32'h0000_0000;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign apb_sel   = sel_q;
    assign apb_ena   = ena_q;
    assign apb_write = write_q;
    assign apb_addr  = addr_q;
    assign apb_wdata = wdata_q;
    assign apb_pstb  = pstb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: transaction-timeline reference model, per-cycle compare,
// directed corner cases and randomized traffic with a short timeout.
module tb_apb_initiator;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] apb_addr, apb_wdata, apb_rdata;
    logic        apb_sel, apb_write, apb_ena, apb_rready;
    logic [3:0]  apb_pstb;

    apb_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb_addr  (apb_addr),
        .apb_sel   (apb_sel),
        .apb_write (apb_write),
        .apb_ena   (apb_ena),
        .apb_wdata (apb_wdata),
        .apb_pstb  (apb_pstb),
        .apb_rdata (apb_rdata),
        .apb_rready(apb_rready)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wt;      // wait states before rready; wt >= T means timeout
        logic [31:0] rdata;
    } req_t;

    req_t pend[$];
    req_t cur;
    int   total = 0, bad = 0, cyc = 0;
    bit   busy = 0, in_reset = 1;
    int   a_cyc = 0, acc_len = 0, last_ph = 0, last_k = 0;
    int   n_accept = 0, n_resp = 0, ena_cnt = 0;
    int   resp_cyc[$];
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rdata = 0, cap_rdata = 0;
    logic [3:0]  exp_pstb = 0;
    logic        exp_write = 0, exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One cycle: compare outputs at the negedge, then drive inputs for the next edge.
    // Phase of the current transfer: 0 idle, 1 setup, 2 access, 3 resp.
    task automatic step();
        int off, ph, k;
        @(negedge clock);
        cyc++;
        off = cyc - a_cyc;
        if (busy && off >= acc_len + 3) busy = 0;
        if (!busy)                   ph = 0;
        else if (off == 1)           ph = 1;
        else if (off <= acc_len + 1) ph = 2;
        else                         ph = 3;
        k = off - 2;
        if (ph == 1) begin
            exp_addr  = cur.addr;
            exp_wdata = cur.wdata;
            exp_write = cur.write;
            exp_pstb  = cur.write ? cur.strb : 4'h0;
        end
        if (ph == 3) begin
            exp_err   = (cur.wt >= T);
            exp_rdata = (exp_err || cur.write) ? 32'h0 : cap_rdata;
        end
        if (!in_reset) begin
            chk("req_ready", 32'(req_ready), 32'(ph == 0));
            chk("apb_sel",   32'(apb_sel),   32'(ph == 1 || ph == 2));
            chk("apb_ena",   32'(apb_ena),   32'(ph == 2));
            chk("rsp_valid", 32'(rsp_valid), 32'(ph == 3));
            chk("apb_addr",  apb_addr,       exp_addr);
            chk("apb_wdata", apb_wdata,      exp_wdata);
            chk("apb_write", 32'(apb_write), 32'(exp_write));
            chk("apb_pstb",  32'(apb_pstb),  32'(exp_pstb));
            chk("rsp_rdata", rsp_rdata,      exp_rdata);
            chk("rsp_err",   32'(rsp_err),   32'(exp_err));
            if (rsp_valid === 1'b1) begin
                n_resp++;
                resp_cyc.push_back(cyc);
            end
            if (apb_ena === 1'b1) ena_cnt++;
        end
        last_ph = ph;
        last_k  = k;

        if (in_reset) begin
            req_valid = 1'b0;
        end else if (pend.size() > 0) begin
            req_valid = 1'b1;
            req_write = pend[0].write;
            req_addr  = pend[0].addr;
            req_wdata = pend[0].wdata;
            req_strb  = pend[0].strb;
            if (ph == 0) begin
                cur      = pend.pop_front();
                busy     = 1;
                a_cyc    = cyc;
                acc_len  = (cur.wt < T) ? cur.wt + 1 : T;
                n_accept++;
                ena_cnt  = 0;
            end
        end else begin
            // Noise while busy must be ignored; idle with nothing queued stays quiet.
            req_valid = (ph != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_strb  = 4'($urandom);
        end

        if (ph == 2 && k == cur.wt) begin
            apb_rready = 1'b1;
            apb_rdata  = cur.rdata;
            cap_rdata  = cur.rdata;
        end else if (ph == 2) begin
            apb_rready = 1'b0;
            apb_rdata  = $urandom;
        end else begin
            apb_rready = 1'($urandom_range(0, 1));
            apb_rdata  = $urandom;
        end
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        do begin
            step();
            n++;
        end while ((last_ph != 0 || busy || pend.size() > 0) && n < maxc);
        if (n >= maxc) begin
            total++;
            bad++;
            $display("FAIL run_timeout cyc=%0d actual=%0d cycles required<%0d", cyc, n, maxc);
        end
    endtask

    function automatic req_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int wt, input logic [31:0] rd);
        req_t r;
        r.write = w; r.addr = a; r.wdata = d; r.strb = s; r.wt = wt; r.rdata = rd;
        return r;
    endfunction

    initial begin
        int nr0, na0;
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        apb_rdata = 0; apb_rready = 0;
        repeat (3) step();
        rst_n = 1'b1;
        in_reset = 0;
        step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_addr",  apb_addr,       32'd0);
        chk("rst_rdata", rsp_rdata,      32'd0);

        // Zero-wait write.
        pend.push_back(mk(1, 32'h0, 32'h000A_5A5A, 4'hF, 0, 32'h0));
        run_until_idle(20);
        chk("w_latency", 32'(resp_cyc[$] - a_cyc), 32'd3);
        chk("w_ena_cycles", 32'(ena_cnt), 32'd1);
        chk("w_err", 32'(rsp_err), 32'd0);
        chk("w_pstb", 32'(apb_pstb), 32'hF);
        chk("w_rdata", rsp_rdata, 32'h0);

        // Read with two wait states; strobe must be masked.
        pend.push_back(mk(0, 32'h4, 32'h1111_2222, 4'hA, 2, 32'h0001_2345));
        run_until_idle(20);
        chk("r_ena_cycles", 32'(ena_cnt), 32'd3);
        chk("r_latency", 32'(resp_cyc[$] - a_cyc), 32'd5);
        chk("r_rdata", rsp_rdata, 32'h0001_2345);
        chk("r_pstb", 32'(apb_pstb), 32'h0);

        // Timeout: rready never arrives.
        pend.push_back(mk(0, 32'h8, 32'h0, 4'h0, 9, 32'hDEAD_BEEF));
        run_until_idle(20);
        chk("to_ena_cycles", 32'(ena_cnt), 32'd4);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_rdata", rsp_rdata, 32'h0);

        // Ready on the final counted cycle wins over timeout.
        pend.push_back(mk(0, 32'hC, 32'h0, 4'h0, 3, 32'hCAFE_0045));
        run_until_idle(20);
        chk("last_ena_cycles", 32'(ena_cnt), 32'd4);
        chk("last_err", 32'(rsp_err), 32'd0);
        chk("last_rdata", rsp_rdata, 32'hCAFE_0045);

        // Three back-to-back requests with valid held high.
        resp_cyc.delete();
        na0 = n_accept;
        pend.push_back(mk(1, 32'h100, 32'hAAAA_0001, 4'h3, 0, 32'h0));
        pend.push_back(mk(0, 32'h104, 32'h0,         4'h0, 0, 32'h5555_0002));
        pend.push_back(mk(1, 32'h108, 32'hAAAA_0003, 4'hC, 0, 32'h0));
        run_until_idle(40);
        chk("b2b_accepts", 32'(n_accept - na0), 32'd3);
        chk("b2b_resps", 32'(resp_cyc.size()), 32'd3);
        if (resp_cyc.size() == 3) begin
            chk("b2b_gap1", 32'(resp_cyc[1] - resp_cyc[0]), 32'd4);
            chk("b2b_gap2", 32'(resp_cyc[2] - resp_cyc[1]), 32'd4);
        end

        // Reset in the middle of ACCESS.
        nr0 = n_resp;
        pend.push_back(mk(0, 32'h200, 32'h0, 4'h0, 20, 32'h1234_5678));
        for (int n = 0; n < 30 && !(last_ph == 2 && last_k == 1); n++) step();
        chk("mid_in_access", 32'(last_ph == 2 && last_k == 1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel", 32'(apb_sel), 32'd0);
        chk("async_ena", 32'(apb_ena), 32'd0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        in_reset = 1;
        busy = 0;
        exp_addr = 0; exp_wdata = 0; exp_write = 0; exp_pstb = 0; exp_rdata = 0; exp_err = 0;
        repeat (2) step();
        rst_n = 1'b1;
        in_reset = 0;
        pend.push_back(mk(0, 32'h204, 32'h0, 4'h0, 1, 32'h0BAD_F00D));
        run_until_idle(20);
        chk("post_rst_resps", 32'(n_resp - nr0), 32'd1);
        chk("post_rst_rdata", rsp_rdata, 32'h0BAD_F00D);

        // Randomized traffic, sometimes back-to-back, waits spanning the timeout.
        for (int i = 0; i < 300; i++) begin
            int nb = $urandom_range(1, 2);
            for (int j = 0; j < nb; j++) begin
                pend.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                                  $urandom_range(0, 6), $urandom));
            end
            run_until_idle(40);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum ACCESS-phase cycles before the transfer is aborted (range 1..1023).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  initiator can accept a request.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  32  target byte address.
REQ-009 req_wdata  in  32  write data.
REQ-010 req_strb  in  4  write byte strobes.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-013 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-014 apb_addr  out  32  APB address.
REQ-015 apb_sel  out  1  APB select.
REQ-016 apb_write  out  1  APB direction.
REQ-017 apb_ena  out  1  APB enable (ACCESS phase).
REQ-018 apb_wdata  out  32  APB write data.
REQ-019 apb_pstb  out  4  APB byte strobes.
REQ-020 apb_rdata  in  32  responder read data.
REQ-021 apb_rready  in  1  responder ready; completes the ACCESS phase.

Function
REQ-022 SHALL implement the states IDLE, SETUP, ACCESS and RESP.
REQ-023 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge, and the state then becomes SETUP.
REQ-024 SHALL register addr, write, wdata and strb on acceptance and hold them unchanged on the APB outputs through SETUP and ACCESS.
REQ-025 SHALL drive apb_pstb with the registered strobe for writes and 4'b0000 for reads.
REQ-026 SETUP SHALL last exactly one cycle with apb_sel=1 and apb_ena=0, then move to ACCESS.
REQ-027 In ACCESS SHALL drive apb_sel=1 and apb_ena=1.
REQ-028 ACCESS SHALL end on the first cycle with apb_rready=1, and SHALL capture apb_rdata into rsp_rdata on that edge for reads.
REQ-029 SHALL count ACCESS cycles with a counter that resets on entry to SETUP.
REQ-030 If TIMEOUT_CYCLES ACCESS cycles pass without apb_rready, SHALL end ACCESS with rsp_err=1 and rsp_rdata=32'h0000_0000.
REQ-031 When apb_rready=1 on the final counted cycle, SHALL treat the transfer as a normal completion (rready wins).
REQ-032 RESP SHALL last one cycle with rsp_valid=1; rsp_err=0 unless timed out; no response back-pressure; the next state is IDLE.
REQ-033 For writes, rsp_rdata SHALL be 32'h0000_0000.
REQ-034 Minimum latency SHALL be: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3; each wait state adds one cycle.
REQ-035 In IDLE and RESP SHALL drive apb_sel=0 and apb_ena=0; apb_addr and apb_wdata keep their last values.
REQ-036 req_valid asserted outside IDLE SHALL be ignored with no effect until IDLE.
REQ-037 rsp_rdata and rsp_err SHALL hold their values after RESP until the next completion.

Reset
REQ-038 On rst_n=0, SHALL immediately and asynchronously enter IDLE with apb_sel=0, apb_ena=0, apb_write=0, apb_addr=0, apb_wdata=0, apb_pstb=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout counter=0, and req_ready=1 after release.
REQ-039 A reset during SETUP or ACCESS SHALL abandon the transfer without generating any response pulse.

Structure
REQ-040 Package apb_initiator_pkg SHALL hold the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3) and the default TIMEOUT_CYCLES constant.
REQ-041 The timeout counter SHALL be one sub-module, apb_timeout_cnt, with clear, enable and expired ports, 10 bits wide.

Verification
REQ-042 Write 0x0000_0000 with data 0x000A_5A5A and strb 4'hF, rready tied 1 -> sel/ena follow the 0/0, 1/0, 1/1 sequence; pstb=4'hF; rsp_valid 3 cycles after accept; rsp_err=0.
REQ-043 Read 0x0000_0004 with rdata 0x0001_2345 and 2 wait states -> ACCESS lasts 3 cycles; rsp_rdata=0x0001_2345; pstb=4'h0 throughout.
REQ-044 TIMEOUT_CYCLES=4 with rready held 0 -> exactly 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-045 TIMEOUT_CYCLES=4 with rready=1 on the 4th ACCESS cycle -> rsp_err=0 and data captured.
REQ-046 req_valid held high for 3 back-to-back requests -> each accepted only in IDLE; 4 cycles per transfer; no request dropped or duplicated.
REQ-047 rst_n asserted in mid-ACCESS -> sel/ena drop to 0 without a clock; no rsp_valid; after release a new read completes normally.
